// File: rtl/countdown_tick_ctrl.sv
// Load/prescaler control ahead of the BCD countdown digit chain: load strobe, one tick per DIV cycles, expiry detect.
// Optional macro COUNTDOWN_BLINK_EN: blink toggles every DIV/2 cycles in DONE; otherwise blink mirrors expired.
module countdown_tick_ctrl #(
  parameter int DIV      = 50000000,
  parameter int CNT_W    = 26,
  parameter int LOAD_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       chain_empty,
  output logic       reconfig,
  output logic       tick,
  output logic       running,
  output logic       expired,
  output logic       blink,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int LOAD_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [CNT_W-1:0]  PRESC_LAST = CNT_W'(DIV - 1);
  localparam logic [LOAD_W-1:0] LOAD_LAST  = LOAD_W'(LOAD_CYC - 1);
`ifdef COUNTDOWN_BLINK_EN
  localparam logic [CNT_W-1:0]  BLINK_LAST = CNT_W'(DIV / 2 - 1);
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [LOAD_W-1:0] load_q, load_d;
  logic              tick_d;
  logic              blink_d;

  // stop outranks start, which outranks everything state-specific
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    load_d  = load_q;
    tick_d  = 1'b0;
    blink_d = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      presc_d = '0;
      load_d  = '0;
    end else if (start) begin
      state_d = S_LOAD;
      presc_d = '0;
      load_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          load_d  = '0;
        end
        S_LOAD: begin
          if (load_q == LOAD_LAST) begin
            state_d = S_RUN;
            presc_d = '0;
            load_d  = '0;
          end else begin
            load_d = load_q + LOAD_W'(1);
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (chain_empty) begin
            state_d = S_DONE;
            presc_d = '0;
`ifdef COUNTDOWN_BLINK_EN
            blink_d = 1'b1;
`endif
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + CNT_W'(1);
          end
        end
        S_PAUSE: begin
          if (!pause) state_d = S_RUN;
        end
        S_DONE: begin
`ifdef COUNTDOWN_BLINK_EN
          // prescaler is free in DONE, so it paces the blink half-period
          if (presc_q == BLINK_LAST) begin
            presc_d = '0;
            blink_d = ~blink;
          end else begin
            presc_d = presc_q + CNT_W'(1);
            blink_d = blink;
          end
`else
          presc_d = '0;
`endif
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
          load_d  = '0;
        end
      endcase
    end
`ifndef COUNTDOWN_BLINK_EN
    blink_d = (state_d == S_DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      load_q   <= '0;
      reconfig <= 1'b0;
      tick     <= 1'b0;
      running  <= 1'b0;
      expired  <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      reconfig <= (state_d == S_LOAD);
      tick     <= tick_d;
      running  <= (state_d == S_RUN);
      expired  <= (state_d == S_DONE);
      blink    <= blink_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_countdown_tick_ctrl.sv
// Randomized and directed bench for countdown_tick_ctrl (DIV=4, LOAD_CYC=2) with a phase-level reference model.
module tb_countdown_tick_ctrl;

  localparam int DIV      = 4;
  localparam int CNT_W    = 3;
  localparam int LOAD_CYC = 2;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_PAUSE = 3;
  localparam int P_DONE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       chain_empty = 1'b0;
  logic       reconfig, tick, running, expired, blink;
  logic [2:0] state;

  countdown_tick_ctrl #(.DIV(DIV), .CNT_W(CNT_W), .LOAD_CYC(LOAD_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .chain_empty(chain_empty), .reconfig(reconfig), .tick(tick),
    .running(running), .expired(expired), .blink(blink), .state(state)
  );

  always #5 clk = ~clk;

  // reference model: phase, load cycles left, active run cycles since last tick, age in DONE
  int   m_phase = P_IDLE;
  int   m_load_left = 0;
  int   m_progress = 0;
  int   m_done_age = 0;
  bit   m_tick = 1'b0;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [7:0] model_outputs();
    logic b;
`ifdef COUNTDOWN_BLINK_EN
    b = (m_phase == P_DONE) && (((m_done_age / (DIV / 2)) % 2) == 0);
`else
    b = (m_phase == P_DONE);
`endif
    return {3'(m_phase), m_phase == P_LOAD, m_tick, m_phase == P_RUN, m_phase == P_DONE, b};
  endfunction

  function automatic void model_step(input bit r, input bit sp, input bit st, input bit pz, input bit ce);
    m_tick = 1'b0;
    if (r || sp) begin
      m_phase = P_IDLE;
      m_progress = 0;
    end else if (st) begin
      m_phase = P_LOAD;
      m_load_left = LOAD_CYC;
      m_progress = 0;
    end else begin
      case (m_phase)
        P_LOAD: begin
          if (m_load_left == 1) begin
            m_phase = P_RUN;
            m_progress = 0;
          end else begin
            m_load_left--;
          end
        end
        P_RUN: begin
          if (pz) m_phase = P_PAUSE;
          else if (ce) begin
            m_phase = P_DONE;
            m_done_age = 0;
          end else begin
            m_progress++;
            if (m_progress == DIV) begin
              m_progress = 0;
              m_tick = 1'b1;
            end
          end
        end
        P_PAUSE: if (!pz) m_phase = P_RUN;
        P_DONE: m_done_age++;
        default: ;
      endcase
    end
  endfunction

  // driver: apply one cycle of inputs and record the expected registered response
  task automatic cycle(input bit r, input bit sp, input bit st, input bit pz, input bit ce);
    @(negedge clk);
    rst = r; stop = sp; start = st; pause = pz; chain_empty = ce;
    model_step(r, sp, st, pz, ce);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to_progress(input int p);
    int guard = 0;
    while (!(m_phase == P_RUN && m_progress == p) && guard < 50) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL run_to_progress: no RUN cycle at prescaler %0d within %0d cycles (phase %0d)", p, guard, m_phase);
    end
  endtask

  // monitor: outputs are presented every cycle, compare against the oldest expectation
  always @(posedge clk) begin : monitor
    logic [7:0] e;
    logic [7:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, reconfig, tick, running, expired, blink};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got state=%0d reconfig=%b tick=%b running=%b expired=%b blink=%b, expected state=%0d reconfig=%b tick=%b running=%b expired=%b blink=%b",
                 $time, a[7:5], a[4], a[3], a[2], a[1], a[0], e[7:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin : stimulus
    bit pz_level;
    // reset and idle
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // load and tick cadence
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(15);
    // pause mid-period
    run_to_progress(2);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);
    // expiry at prescaler DIV-1, blink in DONE, then reload
    run_to_progress(3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(7);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    // priority: start+stop in DONE, restart during LOAD
    run_to_progress(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    // reset mid-RUN
    run_to_progress(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    // all-zero load: chain already empty
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // pause while prescaler is at its last value
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_progress(DIV - 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    // randomized traffic
    pz_level = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) pz_level = ~pz_level;
      cycle($urandom_range(0, 249) == 0, $urandom_range(0, 119) == 0,
            $urandom_range(0, 39) == 0, pz_level, $urandom_range(0, 29) == 0);
    end
    idle(2);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
